// File: rtl/gmii_pkg.sv
// Shared GMII definitions: FSM state encoding, framing bytes and CRC-32
// constants, plus a small saturating-increment helper.
package gmii_pkg;

  // Receive FSM state encoding
  localparam logic [2:0] ST_DROP   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_PREAMB = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_END    = 3'd4;

  // Framing bytes
  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  // Reflected Ethernet CRC-32; residue is checked with no final inversion
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // End-of-frame status bundle
  typedef struct packed {
    logic        good;
    logic        bad_crc;
    logic        err;
    logic        short_f;
    logic        long_f;
    logic [15:0] len;
  } rx_status_t;

  // Increment that sticks at all ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_frame_checker_crc32_d8.sv
// Combinational byte-wide CRC-32 update (reflected, LSB first).
// Shared with the transmit side, so it carries no state of its own.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  // Fold the byte in, then shift out eight bits against the polynomial
  always_comb begin
    logic [31:0] w_c;
    w_c = i_crc ^ {24'd0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, checks the FCS,
// measures frame length, withholds the 4 FCS bytes and reports one
// status strobe per frame along with good/bad frame counters.
module gmii_rx_frame_checker
  import gmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        i_gmii_rx_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_gmii_rxd,
  input  logic        i_gmii_rx_dv,
  input  logic        i_gmii_rx_er,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  output logic        o_rx_sof,
  output logic        o_rx_eof,
  output logic        o_rx_good,
  output logic        o_rx_bad_crc,
  output logic        o_rx_err,
  output logic        o_rx_short,
  output logic        o_rx_long,
  output logic [15:0] o_rx_len,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic [7:0]  r_rxd;
  logic        r_dv;
  logic        r_er;
  logic        r_in_valid;   // first real input sample has been captured
  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;
  logic [31:0] r_dly;        // 4-byte delay line, oldest byte in [31:24]
  logic [2:0]  r_dly_cnt;
  logic        r_first;
  logic [15:0] r_len;
  logic        r_err;
  logic        w_data_byte;
  logic        w_enter_data;
  logic        w_emit;
  logic        w_end;
  rx_status_t  w_status;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (r_rxd),
    .o_crc  (w_crc_next)
  );

  // Register the GMII inputs once on entry
  always_ff @(posedge i_gmii_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxd      <= 8'd0;
      r_dv       <= 1'b0;
      r_er       <= 1'b0;
      r_in_valid <= 1'b0;
    end else begin
      r_rxd      <= i_gmii_rxd;
      r_dv       <= i_gmii_rx_dv;
      r_er       <= i_gmii_rx_er;
      r_in_valid <= 1'b1;
    end
  end

  // Next-state logic; END behaves like IDLE so a frame may start right away
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_DROP: begin
        // Only trust DV=0 once a real sample is in the input register
        if (r_in_valid && !r_dv) w_state_next = ST_IDLE;
      end
      ST_IDLE, ST_END: begin
        if (r_dv) w_state_next = (r_rxd == PREAMBLE) ? ST_PREAMB : ST_DROP;
        else      w_state_next = ST_IDLE;
      end
      ST_PREAMB: begin
        if (!r_dv)                   w_state_next = ST_IDLE;
        else if (r_er)               w_state_next = ST_DROP;
        else if (r_rxd == SFD)       w_state_next = ST_DATA;
        else if (r_rxd == PREAMBLE)  w_state_next = ST_PREAMB;
        else                         w_state_next = ST_DROP;
      end
      ST_DATA: begin
        if (!r_dv) w_state_next = ST_END;
      end
      default: w_state_next = ST_DROP;
    endcase
  end

  assign w_data_byte  = (r_state == ST_DATA) && r_dv;
  assign w_enter_data = (r_state == ST_PREAMB) && (w_state_next == ST_DATA);
  assign w_emit       = w_data_byte && (r_dly_cnt == 3'd4);
  assign w_end        = (r_state == ST_END);

  // Status derived from the completed frame while in END
  always_comb begin
    w_status         = '0;
    w_status.len     = r_len;
    w_status.bad_crc = (r_crc != CRC_RESIDUE);
    w_status.err     = r_err;
    w_status.short_f = (r_len < MIN_LEN_W);
    w_status.long_f  = (r_len > MAX_LEN_W);
    w_status.good    = ~(w_status.bad_crc | w_status.err |
                         w_status.short_f | w_status.long_f);
  end

  // FSM state register
  always_ff @(posedge i_gmii_rx_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_DROP;
    else       r_state <= w_state_next;
  end

  // Per-frame CRC, length, error flag and FCS-withholding delay line
  always_ff @(posedge i_gmii_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc     <= CRC_INIT;
      r_dly     <= 32'd0;
      r_dly_cnt <= 3'd0;
      r_first   <= 1'b0;
      r_len     <= 16'd0;
      r_err     <= 1'b0;
    end else if (w_enter_data) begin
      r_crc     <= CRC_INIT;
      r_dly     <= 32'd0;
      r_dly_cnt <= 3'd0;
      r_first   <= 1'b1;
      r_len     <= 16'd0;
      r_err     <= 1'b0;
    end else if (w_data_byte) begin
      r_crc <= w_crc_next;
      r_dly <= {r_dly[23:0], r_rxd};
      r_len <= sat_inc16(r_len);
      r_err <= r_err | r_er;
      if (r_dly_cnt != 3'd4) r_dly_cnt <= r_dly_cnt + 3'd1;
      if (w_emit)            r_first   <= 1'b0;
    end
  end

  // Payload stream, EOF strobe, held status fields and saturating counters
  always_ff @(posedge i_gmii_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_data    <= 8'd0;
      o_rx_valid   <= 1'b0;
      o_rx_sof     <= 1'b0;
      o_rx_eof     <= 1'b0;
      o_rx_good    <= 1'b0;
      o_rx_bad_crc <= 1'b0;
      o_rx_err     <= 1'b0;
      o_rx_short   <= 1'b0;
      o_rx_long    <= 1'b0;
      o_rx_len     <= 16'd0;
      o_good_cnt   <= 16'd0;
      o_bad_cnt    <= 16'd0;
    end else begin
      o_rx_valid <= w_emit;
      o_rx_sof   <= w_emit & r_first;
      if (w_emit) o_rx_data <= r_dly[31:24];
      o_rx_eof <= w_end;
      if (w_end) begin
        o_rx_good    <= w_status.good;
        o_rx_bad_crc <= w_status.bad_crc;
        o_rx_err     <= w_status.err;
        o_rx_short   <= w_status.short_f;
        o_rx_long    <= w_status.long_f;
        o_rx_len     <= w_status.len;
        if (w_status.good) o_good_cnt <= sat_inc16(o_good_cnt);
        else               o_bad_cnt  <= sat_inc16(o_bad_cnt);
      end
    end
  end

endmodule
